eeprom_ctrl: RTL

- Command-level controller for a 24xx-series I2C EEPROM with 16-bit memory addressing.
- Sits directly upstream of the I2C byte engine (i2c_master) and drives its start, nbytes_in, addr_in, rw_in and write_data inputs.
- Consumes the engine's tx_data_req, rx_data_ready, read_data and ready outputs.
- Turns host write/read-burst commands into engine transactions:
  - write = address-pointer bytes followed by data bytes;
  - random read = address-pointer write, then repeated start, then read.

---
 rtl/eeprom_ctrl.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/eeprom_ctrl.sv
// eeprom_ctrl: command-level controller for a 24xx-series I2C EEPROM with
// 16-bit memory addressing, driving an upstream i2c_master byte engine.
// Writes send two address-pointer bytes and then the payload. Random reads
// send an address-pointer write, then a repeated start, then the read.
// Optional feature macro: EEPROM_WR_CYCLE_WAIT_EN. When it is defined, each
// write waits TWR_CYCLES clocks for the EEPROM internal program cycle before
// reporting done.
module eeprom_ctrl #(
    parameter logic [6:0]  DEV_ADDR       = 7'h50,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TWR_CYCLES     = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [15:0] cmd_mem_addr,
    input  logic [7:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic [1:0]  err,
    output logic        m_start,
    output logic [7:0]  m_nbytes,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [7:0]  m_write_data,
    input  logic        m_tx_data_req,
    input  logic        m_rx_data_ready,
    input  logic [7:0]  m_read_data,
    input  logic        m_ready
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LAUNCH, ST_WR_XFER, ST_RD_ADDR,
        ST_RD_XFER, ST_DRAIN, ST_TWR_WAIT, ST_FINISH
    } state_t;

    localparam logic [31:0] TOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_r, state_nx_s;
    logic        rw_r, busy_seen_r, addr_fed_r, start_r;
    logic [15:0] addr_r;
    logic [7:0]  len_r, cnt_r, rx_cnt_r;
    logic [1:0]  err_r;
    logic [31:0] tout_r;
    logic        tx_q_r, rx_q_r, m_rw_r, rd_valid_r, wr_ready_r;
    logic [7:0]  m_nbytes_r, m_write_data_r, rd_data_r;
    logic        accept_s, bad_len_s, tx_edge_s, rx_edge_s;
    logic        timing_s, tout_hit_s, start_kill_s;

    assign accept_s   = cmd_valid && (state_r == ST_IDLE);
    assign bad_len_s  = (cmd_len == 8'd0) || (cmd_len > 8'd253);
    assign tx_edge_s  = m_tx_data_req && !tx_q_r;
    assign rx_edge_s  = m_rx_data_ready && !rx_q_r;
    // The watchdog covers every state in which we wait on the engine.
    assign timing_s   = (state_r == ST_LAUNCH) || (state_r == ST_WR_XFER) ||
                        (state_r == ST_RD_ADDR) || (state_r == ST_RD_XFER) ||
                        (state_r == ST_DRAIN);
    assign tout_hit_s = timing_s && (tout_r == TOUT_LAST);
    // Drop start as soon as the first read byte arrives so the last ACK ends in STOP.
    assign start_kill_s = tout_hit_s || ((state_r == ST_RD_ADDR) && rx_edge_s);

    assign cmd_ready    = (state_r == ST_IDLE);
    assign done         = (state_r == ST_FINISH);
    assign err          = err_r;
    assign m_start      = start_r && !start_kill_s;
    assign m_addr       = DEV_ADDR;
    assign m_rw         = m_rw_r;
    assign m_nbytes     = m_nbytes_r;
    assign m_write_data = m_write_data_r;
    assign rd_data      = rd_data_r;
    assign rd_valid     = rd_valid_r;
    assign wr_ready     = wr_ready_r;

`ifdef EEPROM_WR_CYCLE_WAIT_EN
    localparam logic [31:0] TWR_LAST = 32'(TWR_CYCLES - 1);
    logic [31:0] twr_cnt_r;

    // Program-time counter, running only while waiting after a write
    always_ff @(posedge clk) begin
        if (reset) begin
            twr_cnt_r <= 32'd0;
        end else if (state_r == ST_TWR_WAIT) begin
            twr_cnt_r <= twr_cnt_r + 32'd1;
        end else begin
            twr_cnt_r <= 32'd0;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; the watchdog wins over every other transition
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = bad_len_s ? ST_FINISH : ST_LAUNCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (tout_hit_s) begin
                    state_nx_s = ST_FINISH;
                end else if (m_ready) begin
                    state_nx_s = rw_r ? ST_RD_ADDR : ST_WR_XFER;
                end else begin
                    state_nx_s = ST_LAUNCH;
                end
            end
            ST_WR_XFER: begin
                if (tout_hit_s) begin
                    state_nx_s = ST_FINISH;
                end else if (busy_seen_r && m_ready) begin
`ifdef EEPROM_WR_CYCLE_WAIT_EN
                    state_nx_s = ST_TWR_WAIT;
`else
                    state_nx_s = ST_FINISH;
`endif
                end else begin
                    state_nx_s = ST_WR_XFER;
                end
            end
            ST_RD_ADDR: begin
                if (tout_hit_s) begin
                    state_nx_s = ST_FINISH;
                end else if (rx_edge_s) begin
                    state_nx_s = ST_RD_XFER;
                end else begin
                    state_nx_s = ST_RD_ADDR;
                end
            end
            ST_RD_XFER: begin
                if (tout_hit_s) begin
                    state_nx_s = ST_FINISH;
                end else if ((rx_cnt_r == len_r) && m_ready) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_RD_XFER;
                end
            end
            ST_DRAIN: begin
                // Settle cycle after the engine goes idle.
                if (tout_hit_s) begin
                    state_nx_s = ST_FINISH;
                end else if (rw_r) begin
                    state_nx_s = ST_FINISH;
                end else begin
                    state_nx_s = ST_TWR_WAIT;
                end
            end
            ST_TWR_WAIT: begin
`ifdef EEPROM_WR_CYCLE_WAIT_EN
                if (twr_cnt_r == TWR_LAST) begin
                    state_nx_s = ST_FINISH;
                end else begin
                    state_nx_s = ST_TWR_WAIT;
                end
`else
                state_nx_s = ST_FINISH;
`endif
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Command latch, engine-side drive, byte sequencing, strobes and watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            rw_r           <= 1'b0;
            addr_r         <= 16'd0;
            len_r          <= 8'd0;
            cnt_r          <= 8'd0;
            rx_cnt_r       <= 8'd0;
            err_r          <= 2'd0;
            busy_seen_r    <= 1'b0;
            addr_fed_r     <= 1'b0;
            tout_r         <= 32'd0;
            tx_q_r         <= 1'b0;
            rx_q_r         <= 1'b0;
            start_r        <= 1'b0;
            m_rw_r         <= 1'b0;
            m_nbytes_r     <= 8'd0;
            m_write_data_r <= 8'd0;
            rd_data_r      <= 8'd0;
            rd_valid_r     <= 1'b0;
            wr_ready_r     <= 1'b0;
        end else begin
            tx_q_r     <= m_tx_data_req;
            rx_q_r     <= m_rx_data_ready;
            rd_valid_r <= 1'b0;
            wr_ready_r <= 1'b0;
            if (timing_s && !tx_edge_s && !rx_edge_s) begin
                tout_r <= tout_r + 32'd1;
            end else begin
                tout_r <= 32'd0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rw_r           <= cmd_rw;
                        addr_r         <= cmd_mem_addr;
                        len_r          <= cmd_len;
                        err_r          <= bad_len_s ? 2'd1 : 2'd0;
                        m_write_data_r <= cmd_mem_addr[15:8];
                        cnt_r          <= 8'd0;
                        rx_cnt_r       <= 8'd0;
                        busy_seen_r    <= 1'b0;
                        addr_fed_r     <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    if (m_ready && !tout_hit_s) begin
                        start_r    <= 1'b1;
                        m_rw_r     <= 1'b0;
                        m_nbytes_r <= rw_r ? 8'd2 : (len_r + 8'd2);
                    end
                end
                ST_WR_XFER: begin
                    if (!m_ready) begin
                        busy_seen_r <= 1'b1;
                        start_r     <= 1'b0;
                    end
                    if (tx_edge_s) begin
                        cnt_r <= cnt_r + 8'd1;
                        if (cnt_r == 8'd0) begin
                            m_write_data_r <= addr_r[7:0];
                        end else if (cnt_r <= len_r) begin
                            if (wr_valid) begin
                                m_write_data_r <= wr_data;
                                wr_ready_r     <= 1'b1;
                            end else begin
                                m_write_data_r <= 8'hFF;
                                err_r          <= 2'd3;
                            end
                        end
                    end
                end
                ST_RD_ADDR: begin
                    // Engine picks these up at the repeated start.
                    if (!m_ready) begin
                        m_rw_r     <= 1'b1;
                        m_nbytes_r <= len_r;
                    end
                    if (tx_edge_s && !addr_fed_r) begin
                        m_write_data_r <= addr_r[7:0];
                        addr_fed_r     <= 1'b1;
                    end
                    if (rx_edge_s) begin
                        rd_data_r  <= m_read_data;
                        rd_valid_r <= 1'b1;
                        rx_cnt_r   <= rx_cnt_r + 8'd1;
                        start_r    <= 1'b0;
                    end
                end
                ST_RD_XFER: begin
                    if (rx_edge_s) begin
                        rd_data_r  <= m_read_data;
                        rd_valid_r <= 1'b1;
                        rx_cnt_r   <= rx_cnt_r + 8'd1;
                    end
                end
                default: begin
                end
            endcase
            // An engine that stops responding overrides any other status.
            if (tout_hit_s) begin
                err_r   <= 2'd2;
                start_r <= 1'b0;
            end
        end
    end

endmodule
